// File: rtl/npu_tile_sequencer.sv
// npu_tile_sequencer: job FSM that loads A/B/C buffers, clears, computes K*K steps and writes back N PE results per tile; perf counter via NPU_SEQ_PERF_CNT_EN
module npu_tile_sequencer #(
  parameter int N      = 10,
  parameter int K_SIZE = 3,
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              relu_en,
  input  logic              broadcast_en,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [5:0]        wr_addr,
  output logic [N-1:0]      pe_en,
  output logic [N-1:0]      pe_reg_reset,
  output logic [N-1:0]      pe_mode_sel,
  output logic [3:0]        pe_mux_a_sel,
  output logic [4:0]        pe_mux_b_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_sel,
`ifdef NPU_SEQ_PERF_CNT_EN
  output logic [31:0]       perf_cycles,
`endif
  output logic              busy,
  output logic              done
);
  localparam int AW = N * K_SIZE;
  localparam int KK = K_SIZE * K_SIZE;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_C, CLEAR, COMPUTE, WRITE_BACK, DONE} state_t;
  state_t state_q, state_d;
  logic [TILE_W-1:0] tile_q, tile_d, ntiles_q, ntiles_d;
  logic relu_q, relu_d, bcast_q, bcast_d;
  logic [5:0] addr_q, addr_d;
  logic [4:0] cnt_q, cnt_d;
  // state and job registers; reset returns to IDLE with everything cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tile_q   <= '0;
      ntiles_q <= '0;
      relu_q   <= 1'b0;
      bcast_q  <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tile_q   <= tile_d;
      ntiles_q <= ntiles_d;
      relu_q   <= relu_d;
      bcast_q  <= bcast_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
    end
  end
  // next-state and per-state outputs; addr_q runs continuously through A, B, C on tile 0
  always_comb begin
    state_d      = state_q;
    tile_d       = tile_q;
    ntiles_d     = ntiles_q;
    relu_d       = relu_q;
    bcast_d      = bcast_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    in_ready     = 1'b0;
    wr_addr      = '0;
    pe_en        = '0;
    pe_reg_reset = '0;
    pe_mode_sel  = '0;
    pe_mux_a_sel = '0;
    pe_mux_b_sel = '0;
    out_valid    = 1'b0;
    out_sel      = '0;
    done         = 1'b0;
    busy         = state_q != IDLE;
    case (state_q)
      IDLE: if (start) begin
        ntiles_d = num_tiles;
        relu_d   = relu_en;
        bcast_d  = broadcast_en;
        tile_d   = '0;
        addr_d   = '0;
        cnt_d    = '0;
        state_d  = (num_tiles == '0) ? DONE : LOAD_A;
      end
      LOAD_A, LOAD_B, LOAD_C: begin
        in_ready = 1'b1;
        wr_addr  = addr_q;
        if (in_valid) begin
          addr_d = addr_q + 6'd1;
          if (state_q == LOAD_A && addr_q == 6'(AW - 1)) state_d = (tile_q == '0) ? LOAD_B : CLEAR;
          if (state_q == LOAD_B && addr_q == 6'(2 * AW - 1)) state_d = LOAD_C;
          if (state_q == LOAD_C && addr_q == 6'(2 * AW + K_SIZE - 1)) state_d = CLEAR;
        end
      end
      CLEAR: begin
        pe_reg_reset = '1;
        pe_mode_sel  = {N{relu_q}};
        cnt_d        = '0;
        state_d      = COMPUTE;
      end
      COMPUTE: begin
        pe_en        = '1;
        pe_mode_sel  = {N{relu_q}};
        pe_mux_a_sel = 4'(cnt_q);
        pe_mux_b_sel = cnt_q + (bcast_q ? 5'(KK) : 5'd0);
        cnt_d        = cnt_q + 5'd1;
        if (cnt_q == 5'(KK - 1)) begin
          cnt_d   = '0;
          state_d = WRITE_BACK;
        end
      end
      WRITE_BACK: begin
        out_valid   = 1'b1;
        pe_mode_sel = {N{relu_q}};
        out_sel     = 4'(cnt_q);
        if (out_ready) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(N - 1)) begin
            cnt_d   = '0;
            addr_d  = '0;
            tile_d  = tile_q + TILE_W'(1);
            state_d = (tile_d == ntiles_q) ? DONE : LOAD_A;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_en = in_valid & in_ready;
  end
`ifdef NPU_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;
  // busy-cycle counter restarted by each accepted job, saturating at all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else if (state_q == IDLE && start) perf_q <= '0;
    else if (busy && perf_q != '1) perf_q <= perf_q + 32'd1;
  end
  assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_npu_tile_sequencer.sv
// tb_npu_tile_sequencer: table, directed and random jobs checked against a job-level reference model
module tb_npu_tile_sequencer;
  localparam int N = 10;
  logic clk = 1'b0;
  logic rst_n, start, relu_en, broadcast_en, in_valid, in_ready, wr_en, out_valid, out_ready, busy, done;
  logic [7:0] num_tiles;
  logic [5:0] wr_addr;
  logic [N-1:0] pe_en, pe_reg_reset, pe_mode_sel;
  logic [3:0] pe_mux_a_sel, out_sel;
  logic [4:0] pe_mux_b_sel;
`ifdef NPU_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif
  int checks = 0, failures = 0;
  int busy_cnt, done_cnt, lstall, wstall, clr_cnt, clr_bad;
  int wr_q[$];
  int os_q[$];
  logic [31:0] cmp_q[$];
  logic prev_ov, prev_or;
  logic [3:0] prev_sel;

  npu_tile_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
    .relu_en(relu_en), .broadcast_en(broadcast_en), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .pe_en(pe_en), .pe_reg_reset(pe_reg_reset),
    .pe_mode_sel(pe_mode_sel), .pe_mux_a_sel(pe_mux_a_sel), .pe_mux_b_sel(pe_mux_b_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
`ifdef NPU_SEQ_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {10'd0, in_ready, wr_en, wr_addr, pe_en, pe_reg_reset, pe_mode_sel,
            pe_mux_a_sel, pe_mux_b_sel, out_valid, out_sel, busy, done};
  endfunction

  // per-cycle observer: records transfers and checks handshake rules
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
      prev_or = 1'b0;
      prev_sel = '0;
    end else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (wr_en) wr_q.push_back(int'(wr_addr));
      if (in_ready && !in_valid) lstall++;
      if (out_valid && !out_ready) wstall++;
      if (pe_en != '0) cmp_q.push_back({13'd0, pe_mux_a_sel, pe_mux_b_sel, pe_mode_sel});
      if (pe_reg_reset != '0) begin
        clr_cnt++;
        if (pe_reg_reset != '1 || pe_en != '0) clr_bad++;
      end
      if (out_valid && out_ready) os_q.push_back(int'(out_sel));
      chk("wr_en_handshake", wr_en, in_valid & in_ready);
      if (prev_ov && !prev_or && out_valid) chk("out_sel_hold", out_sel, prev_sel);
      prev_ov = out_valid;
      prev_or = out_ready;
      prev_sel = out_sel;
    end
  end

  // job-level expectation: tile 0 loads 63 words, later tiles 30; 9 steps and N results per tile
  task automatic verify(input int nt, input bit r, input bit b);
    int exp_wr[$];
    int exp_os[$];
    logic [31:0] exp_c[$];
    int err, exp_busy;
    for (int t = 0; t < nt; t++) begin
      for (int a = 0; a < (t == 0 ? 63 : 30); a++) exp_wr.push_back(a);
      for (int s = 0; s < 9; s++) exp_c.push_back(32'(s * 32768 + (s + (b ? 9 : 0)) * 1024 + (r ? 1023 : 0)));
      for (int i = 0; i < N; i++) exp_os.push_back(i);
    end
    chk("wr_count", wr_q.size(), exp_wr.size());
    err = 0;
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) if (wr_q[i] != exp_wr[i]) err++;
    chk("wr_addr_seq_errors", err, 0);
    chk("compute_count", cmp_q.size(), exp_c.size());
    err = 0;
    for (int i = 0; i < cmp_q.size() && i < exp_c.size(); i++) if (cmp_q[i] != exp_c[i]) err++;
    chk("compute_sel_errors", err, 0);
    chk("wb_count", os_q.size(), exp_os.size());
    err = 0;
    for (int i = 0; i < os_q.size() && i < exp_os.size(); i++) if (os_q[i] != exp_os[i]) err++;
    chk("wb_sel_errors", err, 0);
    chk("clear_cycles", clr_cnt, nt);
    chk("clear_bad", clr_bad, 0);
    chk("done_pulses", done_cnt, 1);
    exp_busy = exp_wr.size() + lstall + 10 * nt + N * nt + wstall + 1;
    chk("busy_cycles", busy_cnt, exp_busy);
`ifdef NPU_SEQ_PERF_CNT_EN
    chk("perf_cycles", perf_cycles, exp_busy);
`endif
  endtask

  task automatic clear_mon();
    wr_q.delete();
    os_q.delete();
    cmp_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    lstall = 0;
    wstall = 0;
    clr_cnt = 0;
    clr_bad = 0;
  endtask

  // runs one job from IDLE; rnd randomizes both handshakes every cycle
  task automatic run_job(input int nt, input bit r, input bit b, input bit rnd);
    int cyc;
    clear_mon();
    start = 1'b1;
    num_tiles = 8'(nt);
    relu_en = r;
    broadcast_en = b;
    in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num_tiles = 8'($urandom);
    relu_en = 1'($urandom);
    broadcast_en = 1'($urandom);
    cyc = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      if (rnd) begin
        in_valid = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_job", busy, 0);
    verify(nt, r, b);
  endtask

  typedef struct {int nt; bit r; bit b; int exp_busy; int exp_words;} vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{1, 1'b0, 1'b0, 84, 63};
    tbl[1] = '{2, 1'b1, 1'b1, 134, 93};
    tbl[2] = '{0, 1'b1, 1'b1, 1, 0};
    tbl[3] = '{3, 1'b0, 1'b1, 184, 123};
    tbl[4] = '{1, 1'b1, 1'b0, 84, 63};
    rst_n = 1'b0;
    start = 1'b1;
    num_tiles = 8'd1;
    relu_en = 1'b1;
    broadcast_en = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_out(), 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_outputs", all_out(), 0);
    foreach (tbl[i]) begin
      run_job(tbl[i].nt, tbl[i].r, tbl[i].b, 1'b0);
      chk("tbl_busy", busy_cnt, tbl[i].exp_busy);
      chk("tbl_words", wr_q.size(), tbl[i].exp_words);
    end
    // in_valid toggling through LOAD_A, then a write-back stall at index 4
    clear_mon();
    start = 1'b1;
    num_tiles = 8'd1;
    relu_en = 1'b0;
    broadcast_en = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      in_valid = (c % 2 == 0);
      chk("toggle_addr", wr_addr, (c + 1) / 2);
      @(posedge clk); #1;
    end
    chk("toggle_words", wr_q.size(), 30);
    chk("toggle_next_addr", wr_addr, 30);
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !(out_valid && out_sel == 4'd4); i++) begin
      @(posedge clk); #1;
    end
    chk("reach_out_sel4", out_valid && out_sel == 4'd4, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stalled_out_sel", out_sel, 4);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk); #1;
    end
    chk("reach_done", done, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);
    chk("stall_os_count", os_q.size(), N);
    // reset in the middle of COMPUTE step 4
    clear_mon();
    start = 1'b1;
    num_tiles = 8'd2;
    relu_en = 1'b1;
    broadcast_en = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && !(pe_en != '0 && pe_mux_a_sel == 4'd4); i++) begin
      @(posedge clk); #1;
    end
    chk("reach_step4", pe_mux_a_sel, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midjob_reset_outputs", all_out(), 0);
    @(posedge clk); #1;
    chk("held_reset_outputs", all_out(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(1, 1'b0, 1'b1, 1'b0);
    chk("post_reset_reload", wr_q.size(), 63);
    for (int j = 0; j < 20; j++) begin
      run_job(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
